ras_call_return_decoder: RTL and testbench
==========================================

# ras_call_return_decoder

Front-end block that drives the return address stack: it registers each fetched instruction, recognises MIPS32 calls and returns, and emits exactly one push or pop command per instruction together with the push address. It also turns the stack's top-of-stack output into a return-target prediction for fetch. A saturating shadow depth counter suppresses predictions from an empty stack. Sits between the fetch stage and the return address stack.

## Interface
- DEPTH, 8, stack entry count; must equal the connected stack's depth.
- RA_OFFSET, 8, byte offset from call PC to pushed return address (covers the delay slot).
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- in_valid  in  1  fetch presents an instruction this cycle.
- in_pc  in  32  PC of presented instruction.
- in_instr  in  32  instruction word.
- stall  in  1  downstream stall; hold the stage register.
- flush  in  1  discard the stage-register contents.
- ras_target_pc  in  32  top-of-stack value from the return address stack.
- ras_type  out  2  00 none, 01 push, 10 pop; 11 never driven.
- ras_next_pc  out  32  return address to push.
- out_valid  out  1  stage register holds a valid instruction.
- out_pc  out  32  PC in the stage register.
- pred_valid  out  1  return prediction valid this cycle.
- pred_target  out  32  predicted return target.
- depth  out  $clog2(DEPTH)+1  shadow stack occupancy, 0..DEPTH.

## Operation
- Stage register (valid, pc, instr):
  - Loads in_valid/in_pc/in_instr on each edge where stall=0.
  - Holds its contents when stall=1.
  - flush=1 clears valid on the next edge and takes priority over stall.
- Decode, performed on the stage-register instruction (op = [31:26], funct = [5:0]):
  - CALL: op=000011 (jal).
  - CALL_R: op=000000, funct=001001 (jalr), rd [15:11] = 31. Recognised only when the configuration macro is defined.
  - RET: op=000000, funct=001000 (jr), rs [25:21] = 31.
  - All other instructions decode as OTHER.
- Fire condition: fire = out_valid & ~stall & ~flush. Each instruction therefore fires exactly once, in the cycle it leaves the stage.
- Commands:
  - ras_type = 01 when fire and the instruction is CALL or CALL_R.
  - ras_type = 10 when fire and the instruction is RET.
  - ras_type = 00 otherwise.
- ras_next_pc = out_pc + RA_OFFSET, modulo 2^32. It is driven whenever out_valid=1 and is only meaningful on a push.
- Prediction: pred_valid = (fire & RET & depth != 0). pred_target = ras_target_pc, passed through combinationally in the same cycle.
- Shadow depth counter, updated on the edge after a fire:
  - Push: depth+1, saturating at DEPTH. An overflowing push still issues ras_type=01.
  - Pop: depth-1, saturating at 0. A pop at depth 0 still issues ras_type=10 with pred_valid=0.
- Flush does not change depth. Speculative stack state is not repaired by this block.

## Timing
- Reset values: out_valid=0, out_pc=0, depth=0, ras_type=00, pred_valid=0, ras_next_pc=RA_OFFSET, pred_target follows ras_target_pc.
- Latency from instruction accept to command: 1 cycle. The instruction is accepted on edge N; ras_type is valid in cycle N+1 if that cycle is not stalled.
- The stack applies the command on the following edge. depth updates on that same edge.
- Back-to-back calls and returns are supported with one command per cycle and no bubbles.
- Stall: ras_type=00 and pred_valid=0 for every stalled cycle. The command appears in the first cycle with stall=0.
- Reset asserted mid-stream: the stage register and depth clear on that edge, and no command is issued in the reset cycle.

## Configuration
- RAS_DEC_JALR_EN defined: jalr with rd=31 decodes as CALL_R and pushes.
- Undefined: every jalr decodes as OTHER, and only jal pushes.

## Test plan
- jal at in_pc=0x00400010 → next cycle ras_type=01 and ras_next_pc=0x00400018, then depth=1.
- jal, then jr $31 with ras_target_pc=0x00400018 → pop cycle shows ras_type=10, pred_valid=1, pred_target=0x00400018, then depth=0.
- jr $31 from reset (depth 0) → ras_type=10, pred_valid=0, depth remains 0.
- Nine consecutive jal instructions → nine pushes, depth saturates at 8. A following jr $31 gives pred_valid=1 and depth 7.
- jal held under stall=1 for 3 cycles → ras_type=00 during all 3 cycles and exactly one 01 on release. A flush during the stall → no command, out_valid=0.
- jalr $31 (rd=31) at in_pc=0x1000 → with RAS_DEC_JALR_EN: ras_type=01 and ras_next_pc=0x1008. Without it: ras_type=00 and depth unchanged.

Source files
------------

// File: rtl/ras_call_return_decoder.sv
// Fetch-side decoder for the return address stack: registers each instruction and issues one push/pop per jal/jr $31.
// Optional RAS_DEC_JALR_EN macro: also treats jalr with rd=31 as a call.
module ras_call_return_decoder #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] RA_OFFSET = 32'd8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [31:0]              ras_target_pc,
  output logic [1:0]               ras_type,
  output logic [31:0]              ras_next_pc,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic                     pred_valid,
  output logic [31:0]              pred_target,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  typedef enum logic [1:0] {
    RAS_NONE = 2'b00,
    RAS_PUSH = 2'b01,
    RAS_POP  = 2'b10
  } ras_cmd_t;

  typedef enum logic [1:0] {
    CLS_OTHER,
    CLS_CALL,
    CLS_CALL_R,
    CLS_RET
  } instr_class_t;

  logic [31:0]  instr_q;
  logic         fire;
  instr_class_t cls;
  ras_cmd_t     cmd;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];
  assign rs    = instr_q[25:21];

  // Flush wins over stall; only valid is cleared, pc/instr are don't-care once invalid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      instr_q   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      instr_q   <= in_instr;
    end
  end

`ifdef RAS_DEC_JALR_EN
  logic [4:0] rd;
  logic       instr_unused;
  assign rd           = instr_q[15:11];
  assign instr_unused = ^{instr_q[20:16], instr_q[10:6]};
`else
  logic instr_unused;
  assign instr_unused = ^{instr_q[20:6]};
`endif

  always_comb begin
    cls = CLS_OTHER;
    if (op == 6'b000011) begin
      cls = CLS_CALL;
    end else if (op == 6'b000000) begin
      if (funct == 6'b001000 && rs == 5'd31) begin
        cls = CLS_RET;
      end
`ifdef RAS_DEC_JALR_EN
      else if (funct == 6'b001001 && rd == 5'd31) begin
        cls = CLS_CALL_R;
      end
`endif
    end
  end

  // Gating with resetn keeps a still-valid stage from issuing a command during the reset cycle.
  assign fire = resetn & out_valid & ~stall & ~flush;

  always_comb begin
    cmd = RAS_NONE;
    if (fire) begin
      case (cls)
        CLS_CALL, CLS_CALL_R: cmd = RAS_PUSH;
        CLS_RET:              cmd = RAS_POP;
        default:              cmd = RAS_NONE;
      endcase
    end
  end

  assign ras_type    = cmd;
  assign ras_next_pc = out_pc + RA_OFFSET;
  assign pred_valid  = fire && (cls == CLS_RET) && (depth != '0);
  assign pred_target = ras_target_pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      depth <= '0;
    end else if (cmd == RAS_PUSH) begin
      if (depth != DEPTH_MAX) depth <= depth + DW'(1);
    end else if (cmd == RAS_POP) begin
      if (depth != '0) depth <= depth - DW'(1);
    end
  end

endmodule

// File: tb/tb_ras_call_return_decoder.sv
// Scoreboard bench for ras_call_return_decoder: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_ras_call_return_decoder;

  localparam logic [31:0] JAL    = 32'h0C00_0000;
  localparam logic [31:0] JR31   = 32'h03E0_0008;
  localparam logic [31:0] JR4    = 32'h0080_0008;
  localparam logic [31:0] JALR31 = 32'h0080_F809;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ras_target_pc = '0;
  logic [1:0]  ras_type;
  logic [31:0] ras_next_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic [3:0]  depth;

  ras_call_return_decoder #(.DEPTH(8), .RA_OFFSET(32'd8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .stall(stall), .flush(flush), .ras_target_pc(ras_target_pc), .ras_type(ras_type),
    .ras_next_pc(ras_next_pc), .out_valid(out_valid), .out_pc(out_pc),
    .pred_valid(pred_valid), .pred_target(pred_target), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  t;
    logic        pv;
    logic [31:0] tgt;
    logic [3:0]  d;
    logic        ov;
    logic        chk_npc;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ras_type", e.cyc, 32'(ras_type), 32'(e.t));
      check("pred_valid", e.cyc, 32'(pred_valid), 32'(e.pv));
      check("pred_target", e.cyc, pred_target, e.tgt);
      check("depth", e.cyc, 32'(depth), 32'(e.d));
      check("out_valid", e.cyc, 32'(out_valid), 32'(e.ov));
      if (e.chk_npc) check("ras_next_pc", e.cyc, ras_next_pc, e.npc);
    end
  end

  // Drive one cycle's inputs and queue the outputs expected in that same cycle.
  task automatic step(input logic rn, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic st, input logic fl, input logic [31:0] tgt,
                      input logic [1:0] et, input logic epv, input logic [3:0] ed, input logic eov,
                      input logic chk, input logic [31:0] enpc);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn; in_valid = v; in_pc = pc; in_instr = ins;
    stall = st; flush = fl; ras_target_pc = tgt;
    e.cyc = cyc; e.t = et; e.pv = epv; e.tgt = tgt; e.d = ed; e.ov = eov;
    e.chk_npc = chk; e.npc = enpc;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input logic [31:0] tgt, input logic [1:0] et, input logic epv,
                      input logic [3:0] ed, input logic eov, input logic chk, input logic [31:0] enpc);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, tgt, et, epv, ed, eov, chk, enpc);
  endtask

  initial begin
    // Reset state, then a single jal and its return.
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 32'h8);
    step(1'b1, 1'b1, 32'h0040_0010, JAL, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 32'h8);
    idle(32'h0, 2'b01, 1'b0, 4'd0, 1'b1, 1'b1, 32'h0040_0018);
    step(1'b1, 1'b1, 32'h0040_0100, JR31, 1'b0, 1'b0, 32'h0040_0018, 2'b00, 1'b0, 4'd1, 1'b0, 1'b0, 32'h0);
    idle(32'h0040_0018, 2'b10, 1'b1, 4'd1, 1'b1, 1'b0, 32'h0);
    idle(32'h0040_0018, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
    // jr $31 at depth 0: pop without prediction.
    step(1'b1, 1'b1, 32'h0000_0200, JR31, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
    idle(32'h0, 2'b10, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
    // jr $4 is not a return.
    step(1'b1, 1'b1, 32'h0000_0300, JR4, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0);
    // Nine back-to-back jal: depth saturates at 8, then a jr predicts and drops to 7.
    for (int k = 0; k < 9; k++) begin
      if (k == 0)
        step(1'b1, 1'b1, 32'h1000, JAL, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
      else
        step(1'b1, 1'b1, 32'h1000 + 32'(4 * k), JAL, 1'b0, 1'b0, 32'h0,
             2'b01, 1'b0, 4'(k - 1), 1'b1, 1'b1, 32'h1008 + 32'(4 * (k - 1)));
    end
    step(1'b1, 1'b1, 32'h2000, JR31, 1'b0, 1'b0, 32'h1028, 2'b01, 1'b0, 4'd8, 1'b1, 1'b1, 32'h1028);
    idle(32'h1028, 2'b10, 1'b1, 4'd8, 1'b1, 1'b0, 32'h0);
    idle(32'h1028, 2'b00, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0);
    // jal held for three stalled cycles, one push on release.
    step(1'b1, 1'b1, 32'h3000, JAL, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 4'd7, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 2'b01, 1'b0, 4'd7, 1'b1, 1'b1, 32'h3008);
    idle(32'h0, 2'b00, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0);
    // Flush during a stall discards the jal.
    step(1'b1, 1'b1, 32'h4000, JAL, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 2'b00, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0);
    idle(32'h0, 2'b00, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0);
    // Reset arriving while a jr is staged: no command, everything clears.
    step(1'b1, 1'b1, 32'h5000, JR31, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd8, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 32'h8);
    // jalr $31 depends on the build option.
    step(1'b1, 1'b1, 32'h1000, JALR31, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
`ifdef RAS_DEC_JALR_EN
    idle(32'h0, 2'b01, 1'b0, 4'd0, 1'b1, 1'b1, 32'h1008);
    idle(32'h0, 2'b00, 1'b0, 4'd1, 1'b0, 1'b0, 32'h0);
`else
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 32'h1008);
    idle(32'h0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
`endif
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
